// File: rtl/div_if.sv
// EX-stage <-> divider handshake: operands and start in, {remainder, quotient} and status out.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               div_start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stallreq_for_ex;

  modport master (
    output div_start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stallreq_for_ex
  );

  modport slave (
    input  div_start, signed_div, opdata1, opdata2, annul,
    output result, ready, stallreq_for_ex
  );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider with its own sequencing FSM; one quotient bit per cycle,
// stalls EX until the sign-corrected {remainder, quotient} is ready.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sign_reg;
  logic               neg1_reg;
  logic               neg2_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH-1:0]   partrem_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               ready_reg;

  logic               start_ok;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               take;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign start_ok = bus.div_start && !bus.annul;

  assign mag1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
  assign mag2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

  // Trial subtraction: the true difference is below the divisor when taken,
  // so a WIDTH-bit wrapping subtract is exact.
  assign shifted = {partrem_reg, quo_reg[WIDTH-1]};
  assign take    = shifted >= {1'b0, divisor_reg};
  assign diff    = shifted[WIDTH-1:0] - divisor_reg;

  assign quo_fix = (sign_reg && (neg1_reg ^ neg2_reg)) ? -quo_reg : quo_reg;
  assign rem_fix = (sign_reg && neg1_reg) ? -partrem_reg : partrem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = (bus.opdata2 == '0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: state_next = END;
      ON: begin
        if (bus.annul) begin
          state_next = IDLE;
        end else if (cnt_reg == LAST_CNT) begin
          state_next = END;
        end
      end
      END: begin
        if (bus.annul || !bus.div_start) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      sign_reg    <= 1'b0;
      neg1_reg    <= 1'b0;
      neg2_reg    <= 1'b0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      partrem_reg <= '0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg  <= 1'b0;
          result_reg <= '0;
          if (start_ok && bus.opdata2 != '0) begin
            quo_reg     <= mag1;
            divisor_reg <= mag2;
            sign_reg    <= bus.signed_div;
            neg1_reg    <= bus.opdata1[WIDTH-1];
            neg2_reg    <= bus.opdata2[WIDTH-1];
            cnt_reg     <= '0;
            partrem_reg <= '0;
          end
        end
        BY_ZERO: begin
          result_reg <= '0;
        end
        ON: begin
          if (!bus.annul) begin
            if (cnt_reg == LAST_CNT) begin
              result_reg <= {rem_fix, quo_fix};
            end else begin
              partrem_reg <= take ? diff : shifted[WIDTH-1:0];
              quo_reg     <= {quo_reg[WIDTH-2:0], take};
              cnt_reg     <= cnt_reg + 1'b1;
            end
          end
        end
        END: begin
          // Result stays up while EX keeps div_start high; dropping it clears the output.
          if (bus.annul || !bus.div_start) begin
            ready_reg  <= 1'b0;
            result_reg <= '0;
          end else begin
            ready_reg  <= 1'b1;
          end
        end
        default: ready_reg <= 1'b0;
      endcase
    end
  end

  assign bus.result          = result_reg;
  assign bus.ready           = ready_reg;
  assign bus.stallreq_for_ex = bus.div_start & ~ready_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: stimulus pushes expected results, a monitor
// pops and compares each time ready rises.
module tb_div_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];
  logic        ready_prev;

  div_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: one comparison per rising ready.
  always @(negedge clk) begin
    if (bus.ready === 1'b1 && ready_prev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got result %h with no operation pending", bus.result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (bus.result !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", bus.result, e);
        end else begin
          $display("ok   result: %h", bus.result);
        end
      end
    end
    ready_prev = bus.ready;
  end

  // Called at 1 time unit after a rising edge; the next edge samples the start.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int lat, input logic [63:0] exp,
                         input int hold, input bit drop);
    int n;
    bit stall_ok;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.signed_div = s;
    bus.div_start  = 1'b1;
    exp_q.push_back(exp);
    #1;
    chk({name, " stall_on"}, 64'(bus.stallreq_for_ex), 64'd1);
    @(posedge clk);
    #1;
    // Operands must be ignored once the operation is under way.
    bus.opdata1    = ~a;
    bus.opdata2    = '0;
    bus.signed_div = ~s;
    n = 0;
    stall_ok = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.ready) break;
      if (!bus.stallreq_for_ex) stall_ok = 1'b0;
    end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " stall_held"}, 64'(stall_ok), 64'd1);
    chk({name, " stall_off"}, 64'(bus.stallreq_for_ex), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({name, " hold_ready"}, 64'(bus.ready), 64'd1);
      chk({name, " hold_result"}, bus.result, exp);
    end
    if (drop) begin
      bus.div_start = 1'b0;
      @(posedge clk);
      #1;
      chk({name, " drop_ready"}, 64'(bus.ready), 64'd0);
      chk({name, " drop_result"}, bus.result, 64'd0);
    end
  endtask

  initial begin
    bit quiet;
    checks = 0;
    errors = 0;
    ready_prev = 1'b0;
    bus.div_start  = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset ready", 64'(bus.ready), 64'd0);
    chk("reset result", bus.result, 64'd0);
    chk("reset stall", 64'(bus.stallreq_for_ex), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_div("u100_7",      32'd100,        32'd7,          1'b0, 34, {32'h2, 32'hE},               5, 1'b1);
    run_div("s-7_2",       32'hFFFFFFF9,   32'h2,          1'b1, 34, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 1'b1);
    run_div("s7_-2",       32'h7,          32'hFFFFFFFE,   1'b1, 34, {32'h1, 32'hFFFFFFFD},        0, 1'b1);
    run_div("u_fff9_2",    32'hFFFFFFF9,   32'h2,          1'b0, 34, {32'h1, 32'h7FFFFFFC},        0, 1'b1);
    run_div("s_min_-1",    32'h80000000,   32'hFFFFFFFF,   1'b1, 34, {32'h0, 32'h80000000},        1, 1'b1);
    run_div("u_zero",      32'h1234,       32'h0,          1'b0, 2,  64'd0,                        1, 1'b1);
    run_div("s_zero",      32'hFFFFFF00,   32'h0,          1'b1, 2,  64'd0,                        0, 1'b1);

    // Flush after 10 iterations: must return to IDLE without a result.
    bus.opdata1 = 32'hFFFFFFFF;
    bus.opdata2 = 32'h10;
    bus.signed_div = 1'b0;
    bus.div_start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 bus.annul = 1'b1;
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    bus.div_start = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready) quiet = 1'b0;
    end
    chk("annul no_ready", 64'(quiet), 64'd1);
    run_div("u_ffff_10",   32'hFFFFFFFF,   32'h10,         1'b0, 34, {32'hF, 32'h0FFFFFFF},        0, 1'b1);

    // annul in IDLE blocks the start even while div_start stays high.
    bus.opdata1 = 32'd5;
    bus.opdata2 = 32'd1;
    bus.annul = 1'b1;
    bus.div_start = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready) quiet = 1'b0;
    end
    chk("idle_annul no_start", 64'(quiet), 64'd1);
    bus.annul = 1'b0;
    bus.div_start = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-ON.
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    bus.div_start = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_on ready", 64'(bus.ready), 64'd0);
    chk("rst_on result", bus.result, 64'd0);
    bus.div_start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_div("after_rst",   32'd100,        32'd7,          1'b0, 34, {32'h2, 32'hE},               0, 1'b1);

    // Asynchronous reset while a result is being held: outputs clear immediately.
    run_div("rst_end",     32'd7,          32'hFFFFFFFE,   1'b1, 34, {32'h1, 32'hFFFFFFFD},        2, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("rst_end ready", 64'(bus.ready), 64'd0);
    chk("rst_end result", bus.result, 64'd0);
    bus.div_start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_div("after_rst2",  32'hFFFFFFF9,   32'h2,          1'b1, 34, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
